// File: rtl/apb_master_multi_slave_pkg.sv
// Shared definitions for the multi-slave APB master: FSM encoding,
// transfer direction constants and the address-to-slave decode helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } apb_state_t;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  // Slave index is the top sel_bits of an addr_width-bit byte address.
  function automatic logic [3:0] addr_to_idx(input logic [31:0] addr,
                                             input int addr_width,
                                             input int sel_bits);
    return 4'((addr >> (addr_width - sel_bits)) & ((32'd1 << sel_bits) - 32'd1));
  endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// Return-path multiplexer: picks PREADY, PRDATA and PSLVERR of the slave
// addressed by idx. An index with no slave behind it returns all zeros.
module apb_slave_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_BITS   = 2
) (
  input  logic [SEL_BITS-1:0]              idx,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pslverr,
  output logic                             sel_ready,
  output logic [DATA_WIDTH-1:0]            sel_rdata,
  output logic                             sel_slverr
);

  // Select the addressed slave's return signals.
  always_comb begin
    sel_ready  = 1'b0;
    sel_rdata  = '0;
    sel_slverr = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx == SEL_BITS'(k)) begin
        sel_ready  = pready[k];
        sel_rdata  = prdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_slverr = pslverr[k];
      end
    end
  end

endmodule

// File: rtl/apb_master_multi_slave.sv
// APB master driving NUM_SLAVES slaves from a valid/ready command port.
// Optional ACCESS watchdog: define APB_MASTER_TIMEOUT_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a command; CMD_READY_o high
// SETUP  | PSEL asserted, PENABLE low, one cycle
// ACCESS | PSEL and PENABLE high, waiting for the selected PREADY
// DECERR | address decodes to no slave; error response next cycle
module apb_master_multi_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_BITS       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK_i,
  input  logic                             PRESETn_i,
  input  logic                             CMD_VALID_i,
  output logic                             CMD_READY_o,
  input  logic                             CMD_WRITE_i,
  input  logic [ADDR_WIDTH-1:0]            CMD_ADDR_i,
  input  logic [DATA_WIDTH-1:0]            CMD_WDATA_i,
  input  logic [DATA_WIDTH/8-1:0]          CMD_STRB_i,
  output logic                             RSP_VALID_o,
  output logic [DATA_WIDTH-1:0]            RSP_RDATA_o,
  output logic                             RSP_ERR_o,
  output logic [ADDR_WIDTH-1:0]            PADDR_o,
  output logic                             PWRITE_o,
  output logic [NUM_SLAVES-1:0]            PSEL_o,
  output logic                             PENABLE_o,
  output logic [DATA_WIDTH-1:0]            PWDATA_o,
  output logic [DATA_WIDTH/8-1:0]          PSTRB_o,
  input  logic [NUM_SLAVES-1:0]            PREADY_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_i,
  input  logic [NUM_SLAVES-1:0]            PSLVERR_i
);

  localparam logic [SEL_BITS:0]     SLAVE_LIMIT = (SEL_BITS + 1)'(NUM_SLAVES);
  localparam logic [NUM_SLAVES-1:0] SEL_ONE     = NUM_SLAVES'(1);

  apb_state_t            state;
  apb_state_t            state_nxt;
  logic [SEL_BITS-1:0]   cmd_idx;
  logic [SEL_BITS-1:0]   idx_q;
  logic                  cmd_fire;
  logic                  cmd_in_range;
  logic                  sel_ready;
  logic                  sel_slverr;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  xfer_done;
  logic                  xfer_abort;

  assign CMD_READY_o  = (state == IDLE);
  assign cmd_fire     = CMD_VALID_i & CMD_READY_o;
  assign cmd_idx      = SEL_BITS'(addr_to_idx(32'(CMD_ADDR_i), ADDR_WIDTH, SEL_BITS));
  assign cmd_in_range = ({1'b0, cmd_idx} < SLAVE_LIMIT);
  assign xfer_done    = (state == ACCESS) && sel_ready;

  apb_slave_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_BITS   (SEL_BITS)
  ) u_slave_mux (
    .idx        (idx_q),
    .pready     (PREADY_i),
    .prdata     (PRDATA_i),
    .pslverr    (PSLVERR_i),
    .sel_ready  (sel_ready),
    .sel_rdata  (sel_rdata),
    .sel_slverr (sel_slverr)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Count ACCESS wait cycles; cleared while in SETUP so each transfer starts at 0.
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !sel_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // The wait cycle that brings the count to TIMEOUT_CYCLES ends the transfer.
  assign xfer_abort = (state == ACCESS) && !sel_ready &&
                      (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
  assign xfer_abort = 1'b0;

  // Watchdog depth has no hardware behind it in this build.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // State register.
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = cmd_in_range ? SETUP : DECERR;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (xfer_done || xfer_abort) state_nxt = IDLE;
      DECERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered APB drive, command latch and response generation.
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      PADDR_o     <= '0;
      PWRITE_o    <= 1'b0;
      PWDATA_o    <= '0;
      PSTRB_o     <= '0;
      PSEL_o      <= '0;
      PENABLE_o   <= 1'b0;
      idx_q       <= '0;
      RSP_VALID_o <= 1'b0;
      RSP_ERR_o   <= 1'b0;
      RSP_RDATA_o <= '0;
    end else begin
      RSP_VALID_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            PADDR_o  <= CMD_ADDR_i;
            PWRITE_o <= CMD_WRITE_i;
            PWDATA_o <= CMD_WDATA_i;
            PSTRB_o  <= (CMD_WRITE_i == DIR_WRITE) ? CMD_STRB_i : '0;
            idx_q    <= cmd_idx;
            PSEL_o   <= cmd_in_range ? (SEL_ONE << cmd_idx) : '0;
          end
        end
        SETUP: begin
          PENABLE_o <= 1'b1;
        end
        ACCESS: begin
          if (xfer_done || xfer_abort) begin
            PSEL_o      <= '0;
            PENABLE_o   <= 1'b0;
            RSP_VALID_o <= 1'b1;
            RSP_ERR_o   <= xfer_abort | sel_slverr;
            RSP_RDATA_o <= (!xfer_abort && !sel_slverr && (PWRITE_o == DIR_READ)) ?
                           sel_rdata : '0;
          end
        end
        DECERR: begin
          RSP_VALID_o <= 1'b1;
          RSP_ERR_o   <= 1'b1;
          RSP_RDATA_o <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_multi_slave.sv
// Scoreboard bench for apb_master_multi_slave with three slaves, so the
// top address quarter decodes to no slave. Also builds with
// APB_MASTER_TIMEOUT_EN defined.
module tb_apb_master_multi_slave;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NS = 3;
  localparam int TO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic       strb;
    int         w;
    logic [7:0] rdata;
    logic       err;
  } xfer_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         acc;
    int         lat;
  } rsp_t;

  logic             pclk = 1'b0;
  logic             presetn = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_write = 1'b0;
  logic [AW-1:0]    cmd_addr = '0;
  logic [DW-1:0]    cmd_wdata = '0;
  logic [DW/8-1:0]  cmd_strb = '0;
  logic             rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic [AW-1:0]    paddr;
  logic             pwrite;
  logic [NS-1:0]    psel;
  logic             penable;
  logic [DW-1:0]    pwdata;
  logic [DW/8-1:0]  pstrb;
  logic [NS-1:0]    pready = '0;
  logic [NS*DW-1:0] prdata = '0;
  logic [NS-1:0]    pslverr = '0;

  int tests = 0;
  int errors = 0;
  int cyc = 0;

  xfer_t slv_q[$];
  rsp_t  exp_q[$];

  apb_master_multi_slave #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK_i      (pclk),
    .PRESETn_i   (presetn),
    .CMD_VALID_i (cmd_valid),
    .CMD_READY_o (cmd_ready),
    .CMD_WRITE_i (cmd_write),
    .CMD_ADDR_i  (cmd_addr),
    .CMD_WDATA_i (cmd_wdata),
    .CMD_STRB_i  (cmd_strb),
    .RSP_VALID_o (rsp_valid),
    .RSP_RDATA_o (rsp_rdata),
    .RSP_ERR_o   (rsp_err),
    .PADDR_o     (paddr),
    .PWRITE_o    (pwrite),
    .PSEL_o      (psel),
    .PENABLE_o   (penable),
    .PWDATA_o    (pwdata),
    .PSTRB_o     (pstrb),
    .PREADY_i    (pready),
    .PRDATA_i    (prdata),
    .PSLVERR_i   (pslverr)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  function automatic xfer_t mk(input logic [7:0] addr, input logic wr, input logic [7:0] wdata,
                               input logic strb, input int w, input logic [7:0] rdata,
                               input logic err);
    xfer_t t;
    t.addr = addr; t.wr = wr; t.wdata = wdata; t.strb = strb;
    t.w = w; t.rdata = rdata; t.err = err;
    return t;
  endfunction

  // Reference model: response and acceptance-to-sample latency from the
  // address quarter, the slave's behaviour and the watchdog rule.
  function automatic rsp_t model(input xfer_t t, input int acc);
    rsp_t r;
    int   idx;
    idx     = int'(t.addr) / 64;
    r.acc   = acc;
    r.rdata = 8'h00;
    r.err   = 1'b1;
    if (idx >= NS) begin
      r.lat = 2;
    end else if (TO_EN && t.w >= TO) begin
      r.lat = 2 + TO;
    end else begin
      r.lat   = 3 + t.w;
      r.err   = t.err;
      r.rdata = (t.wr || t.err) ? 8'h00 : t.rdata;
    end
    return r;
  endfunction

  task automatic send(input xfer_t t, output int acc);
    int n;
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = t.wr;
    cmd_addr  = t.addr;
    cmd_wdata = t.wdata;
    cmd_strb  = t.strb;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    acc = 0;
    if (!cmd_ready) begin
      check("cmd_ready_wait", 32'(cmd_ready), 1);
      cmd_valid = 1'b0;
    end else begin
      acc = cyc + 1;
      exp_q.push_back(model(t, acc));
      if (int'(t.addr) / 64 < NS) slv_q.push_back(t);
      @(posedge pclk);
    end
  endtask

  task automatic idle();
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  // Monitor (response scoreboard) and slave model, both on the falling edge.
  xfer_t cur;
  bit    active = 1'b0;
  int    acnt = 0;
  int    cidx = 0;

  always @(negedge pclk) begin
    if (!presetn) begin
      exp_q.delete();
      slv_q.delete();
      active = 1'b0;
      pready = '0;
      pslverr = '0;
      prdata = '0;
    end else begin
      check("psel_onehot", ($countones(psel) <= 1) ? 32'd1 : 32'd0, 1);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
        end
      end

      pready  = NS'($urandom);
      pslverr = NS'($urandom);
      prdata  = (NS*DW)'($urandom);
      if (psel != '0 && !penable) begin
        if (slv_q.size() == 0) begin
          check("setup_expected", 32'(psel), 0);
        end else begin
          cur    = slv_q.pop_front();
          active = 1'b1;
          acnt   = 0;
          cidx   = int'(cur.addr) / 64;
          check("setup_psel", 32'(psel), 32'd1 << cidx);
          check("setup_paddr", 32'(paddr), 32'(cur.addr));
          check("setup_pwrite", 32'(pwrite), 32'(cur.wr));
          check("setup_pstrb", 32'(pstrb), cur.wr ? 32'(cur.strb) : 32'd0);
          if (cur.wr) check("setup_pwdata", 32'(pwdata), 32'(cur.wdata));
        end
      end else if (active && psel != '0 && penable) begin
        check("access_psel", 32'(psel), 32'd1 << cidx);
        check("access_paddr", 32'(paddr), 32'(cur.addr));
        if (acnt >= cur.w) begin
          pready[cidx]             = 1'b1;
          prdata[cidx*DW +: DW]    = cur.rdata;
          pslverr[cidx]            = cur.err;
        end else begin
          pready[cidx] = 1'b0;
        end
        acnt++;
      end else if (psel == '0) begin
        active = 1'b0;
      end
    end
  end

  initial begin
    xfer_t t;
    int    acc;
    int    prev;
    int    n;

    #1 presetn = 1'b0;
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_psel", 32'(psel), 0);
    check("rst_penable", 32'(penable), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_bus", {paddr, pwdata, 7'd0, pwrite, 7'd0, pstrb}, 0);
    check("rst_rsp", {23'd0, rsp_err, rsp_rdata}, 0);
    repeat (2) @(negedge pclk);
    #1 presetn = 1'b1;

    // Directed cases.
    send(mk(8'h15, 1'b1, 8'h28, 1'b1, 0, 8'h00, 1'b0), acc);
    idle();
    send(mk(8'h84, 1'b0, 8'h00, 1'b0, 3, 8'h5A, 1'b0), acc);
    idle();
    send(mk(8'h47, 1'b0, 8'h00, 1'b0, 1, 8'hA5, 1'b1), acc);
    idle();
    send(mk(8'hC0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0), acc);
    idle();
    send(mk(8'h0C, 1'b0, 8'h00, 1'b0, 20, 8'h3C, 1'b0), acc);
    send(mk(8'h9E, 1'b0, 8'h00, 1'b0, 0, 8'hC3, 1'b0), acc);
    idle();

    // Back-to-back zero-wait writes with valid held high.
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      t = mk({2'($urandom_range(0, NS - 1)), 6'($urandom)}, 1'b1, 8'($urandom),
             1'($urandom), 0, 8'h00, 1'($urandom));
      send(t, acc);
      if (i > 0) check("b2b_interval", 32'(acc - prev), 3);
      prev = acc;
    end
    idle();
    repeat (4) @(negedge pclk);

    // Reset in the middle of a long ACCESS phase.
    send(mk(8'h22, 1'b0, 8'h00, 1'b0, 10, 8'h77, 1'b0), acc);
    idle();
    n = 0;
    while (!penable && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check("reach_access", 32'(penable), 1);
    #2 presetn = 1'b0;
    #1;
    check("midrst_psel", 32'(psel), 0);
    check("midrst_penable", 32'(penable), 0);
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_cmd_ready", 32'(cmd_ready), 1);
    check("midrst_bus", {paddr, pwdata, 7'd0, pwrite, 7'd0, pstrb}, 0);
    repeat (2) @(negedge pclk);
    #1 presetn = 1'b1;
    repeat (12) @(negedge pclk);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      t = mk(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
             $urandom_range(0, 4), 8'($urandom), ($urandom_range(0, 3) == 0));
      send(t, acc);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge pclk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 0);
    repeat (3) @(negedge pclk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
